// File: rtl/pipelined_write_rx.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_write_rx
// Brief    : Assembles a pipelined write (cmd cycle + 1..MAX_WR_CYCLES data
//            cycles) into one parallel write with wdone/error signalling.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_write_rx #(
    parameter int MAX_WR_CYCLES = 4,
    parameter int WR_WIDTH      = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WR_WIDTH+1:0]               wr_bus,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] out_dat,
    output logic [2:0]                        out_num_cycles,
    output logic [2:0]                        out_write_type,
    output logic                              wdone,
    output logic                              err_proto,
    output logic                              err_ovfl
);

    localparam int BW = WR_WIDTH + 2;
    localparam int DW = MAX_WR_CYCLES * WR_WIDTH;

    localparam logic [1:0] c_CT_IDLE  = 2'd0;
    localparam logic [1:0] c_CT_VALID = 2'd1;
    localparam logic [1:0] c_CT_DONE  = 2'd2;
    localparam logic [2:0] c_WT_STD   = 3'd0;
    localparam logic [2:0] c_WT_MULTI = 3'd1;
    localparam logic [2:0] c_WT_MAXOK = 3'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [2:0]          r_exp;
    logic [2:0]          r_type;
    logic [DW-1:0]       r_buf;
    logic [DW-1:0]       w_buf_nxt;
    logic                r_out_vld;
    logic [DW-1:0]       r_out_dat;
    logic [2:0]          r_out_num;
    logic [2:0]          r_out_type;
    logic                r_wdone;
    logic                r_err_proto;
    logic                r_err_ovfl;

    logic                w_accept;
    logic                w_store;
    logic                w_complete;
    logic                w_err;
    logic                w_wdone;
    logic                w_last;

    // Bus fields: the same wires are read as cmd or data depending on state.
    logic                w_cmd_vld;
    logic [BW-6:0]       w_cmd_rsvd;
    logic [1:0]          w_cmd_num;
    logic [2:0]          w_cmd_type;
    logic [1:0]          w_ct;
    logic [WR_WIDTH-1:0] w_dat;

    assign w_cmd_vld  = wr_bus[BW-1];
    assign w_cmd_rsvd = wr_bus[BW-2:5];
    assign w_cmd_num  = wr_bus[4:3];
    assign w_cmd_type = wr_bus[2:0];
    assign w_ct       = wr_bus[BW-1:BW-2];
    assign w_dat      = wr_bus[WR_WIDTH-1:0];
    assign w_last     = ((r_cnt + 3'd1) == r_exp);

    genvar gi;
    for (gi = 0; gi < MAX_WR_CYCLES; gi++) begin : g_byte
        assign w_buf_nxt[gi*WR_WIDTH +: WR_WIDTH] =
            (r_cnt == 3'(gi)) ? w_dat : r_buf[gi*WR_WIDTH +: WR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_store     = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        w_wdone     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_vld) begin
                    if ((w_cmd_rsvd == '0) && (w_cmd_type <= c_WT_MAXOK)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                case (w_ct)
                    c_CT_IDLE: begin
                    end
                    c_CT_VALID: begin
                        w_store = 1'b1;
                        if (w_last) begin
                            // Missing DONE still delivers the write.
                            w_err       = 1'b1;
                            w_complete  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (r_type == c_WT_MULTI) begin
                            w_wdone = 1'b1;
                        end
                    end
                    c_CT_DONE: begin
                        if (w_last) begin
                            w_store    = 1'b1;
                            w_complete = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end
                    default: begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                endcase
                if (w_complete && (r_type != c_WT_STD)) begin
                    w_wdone = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 3'd0;
            r_exp       <= 3'd0;
            r_type      <= 3'd0;
            r_buf       <= '0;
            r_out_vld   <= 1'b0;
            r_out_dat   <= '0;
            r_out_num   <= 3'd0;
            r_out_type  <= 3'd0;
            r_wdone     <= 1'b0;
            r_err_proto <= 1'b0;
            r_err_ovfl  <= 1'b0;
        end else begin
            r_wdone     <= w_wdone;
            r_err_proto <= w_err;
            if (w_accept) begin
                r_exp  <= (w_cmd_num == 2'd0) ? 3'(MAX_WR_CYCLES) : {1'b0, w_cmd_num};
                r_type <= w_cmd_type;
                r_cnt  <= 3'd0;
                r_buf  <= '0;
            end else if (w_store && !w_complete) begin
                r_buf <= w_buf_nxt;
                r_cnt <= r_cnt + 3'd1;
            end
            // Single output slot: a completion while held is dropped.
            if (w_complete && r_out_vld && !out_rdy) begin
                r_err_ovfl <= 1'b1;
            end else if (w_complete) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= w_buf_nxt;
                r_out_num  <= r_exp;
                r_out_type <= r_type;
            end else if (r_out_vld && out_rdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_vld        = r_out_vld;
    assign out_dat        = r_out_dat;
    assign out_num_cycles = r_out_num;
    assign out_write_type = r_out_type;
    assign wdone          = r_wdone;
    assign err_proto      = r_err_proto;
    assign err_ovfl       = r_err_ovfl;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_write_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_write_rx
// Brief    : Directed + randomized bench for pipelined_write_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_write_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_bus;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_dat;
    logic [2:0]  out_num_cycles;
    logic [2:0]  out_write_type;
    logic        wdone;
    logic        err_proto;
    logic        err_ovfl;

    int checks   = 0;
    int failures = 0;
    int wd_cnt   = 0;
    int err_cnt  = 0;
    int vld_cnt  = 0;

    always #5 clk = ~clk;

    pipelined_write_rx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_bus         (wr_bus),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_dat        (out_dat),
        .out_num_cycles (out_num_cycles),
        .out_write_type (out_write_type),
        .wdone          (wdone),
        .err_proto      (err_proto),
        .err_ovfl       (err_ovfl)
    );

    // Count high cycles of the pulse/valid outputs.
    always @(negedge clk) begin
        if (wdone === 1'b1)     wd_cnt++;
        if (err_proto === 1'b1) err_cnt++;
        if (out_vld === 1'b1)   vld_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] b);
        @(negedge clk);
        #1;
        wr_bus = b;
    endtask

    function automatic logic [9:0] cmd(input int wt, input int nf);
        logic [9:0] c;
        c = 10'h200 | 10'((nf & 3) << 3) | 10'(wt & 7);
        return c;
    endfunction

    function automatic logic [9:0] dcy(input int ct, input logic [7:0] b);
        return {2'(ct), b};
    endfunction

    // Reference: a legal write delivers its bytes little-endian, n = 4 when the
    // field is 0, and wdone fires once per data cycle (MULTI), once (SINGLE) or never (STD).
    task automatic run_write(input string tag, input int wt, input int nf,
                             input logic [31:0] bytes, input logic [3:0] gaps);
        int n;
        int w0;
        int e0;
        int exp_wd;
        logic [31:0] ed;
        logic [7:0]  b;
        n  = (nf == 0) ? 4 : nf;
        w0 = wd_cnt;
        e0 = err_cnt;
        ed = 0;
        drive(cmd(wt, nf));
        for (int i = 0; i < n; i++) begin
            b  = bytes[8*i +: 8];
            ed = ed + (32'(b) << (8*i));
            drive(dcy((i == n-1) ? 2 : 1, b));
            if (gaps[i] && i != n-1) drive(10'h000);
        end
        drive(10'h000);
        exp_wd = (wt == 1) ? n : ((wt == 2) ? 1 : 0);
        chk({tag, "_vld"},  32'(out_vld), 32'd1);
        chk({tag, "_dat"},  out_dat, ed);
        chk({tag, "_num"},  32'(out_num_cycles), 32'(n));
        chk({tag, "_type"}, 32'(out_write_type), 32'(wt));
        chk({tag, "_wdone"}, 32'(wd_cnt - w0), 32'(exp_wd));
        chk({tag, "_err"},  32'(err_cnt - e0), 32'd0);
        drive(10'h000);
        chk({tag, "_vld_clr"}, 32'(out_vld), 32'd0);
    endtask

    initial begin
        int w0;
        int e0;
        int v0;
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        wr_bus  = 10'h000;
        repeat (3) @(negedge clk);
        chk("rst_vld",   32'(out_vld), 32'd0);
        chk("rst_dat",   out_dat, 32'd0);
        chk("rst_num",   32'(out_num_cycles), 32'd0);
        chk("rst_type",  32'(out_write_type), 32'd0);
        chk("rst_wdone", 32'(wdone), 32'd0);
        chk("rst_errp",  32'(err_proto), 32'd0);
        chk("rst_ovfl",  32'(err_ovfl), 32'd0);
        #1 rst_n = 1'b1;

        run_write("std2", 0, 2, 32'h0000_3CA5, 4'b0000);
        run_write("multi4", 1, 0, 32'h4433_2211, 4'b0010);

        // Early DONE on SINGLE_WDONE n=3.
        w0 = wd_cnt; e0 = err_cnt; v0 = vld_cnt;
        drive(cmd(2, 3));
        drive(dcy(1, 8'h5A));
        drive(dcy(2, 8'h6B));
        drive(10'h000);
        drive(10'h000);
        chk("early_err",   32'(err_cnt - e0), 32'd1);
        chk("early_vld",   32'(vld_cnt - v0), 32'd0);
        chk("early_wdone", 32'(wd_cnt - w0), 32'd0);
        run_write("after_early", 2, 1, 32'h0000_00C7, 4'b0000);

        // Illegal commands, then VALID data cycles that must be ignored.
        w0 = wd_cnt; e0 = err_cnt; v0 = vld_cnt;
        drive(10'h200 | 10'h020 | 10'h008);
        drive(dcy(1, 8'h55));
        drive(cmd(3, 1));
        drive(dcy(1, 8'h55));
        drive(10'h000);
        drive(10'h000);
        chk("illegal_err",   32'(err_cnt - e0), 32'd2);
        chk("illegal_vld",   32'(vld_cnt - v0), 32'd0);
        chk("illegal_wdone", 32'(wd_cnt - w0), 32'd0);
        run_write("after_illegal", 0, 1, 32'h0000_0081, 4'b0000);

        // Back-to-back n=1 writes with the slot held.
        w0 = wd_cnt;
        out_rdy = 1'b0;
        drive(cmd(2, 1));
        drive(dcy(2, 8'hD1));
        drive(cmd(2, 1));
        drive(dcy(2, 8'hE2));
        drive(10'h000);
        chk("ovfl_vld",   32'(out_vld), 32'd1);
        chk("ovfl_dat",   out_dat, 32'h0000_00D1);
        chk("ovfl_flag",  32'(err_ovfl), 32'd1);
        chk("ovfl_wdone", 32'(wd_cnt - w0), 32'd2);
        out_rdy = 1'b1;
        drive(10'h000);
        chk("ovfl_drain", 32'(out_vld), 32'd0);
        chk("ovfl_sticky", 32'(err_ovfl), 32'd1);

        // Async reset in the middle of a 4-cycle MULTI_WDONE write.
        drive(cmd(1, 0));
        drive(dcy(1, 8'h11));
        drive(dcy(1, 8'h22));
        drive(10'h000);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",   32'(out_vld), 32'd0);
        chk("mid_rst_dat",   out_dat, 32'd0);
        chk("mid_rst_wdone", 32'(wdone), 32'd0);
        chk("mid_rst_ovfl",  32'(err_ovfl), 32'd0);
        chk("mid_rst_num",   32'(out_num_cycles), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_write("post_rst", 0, 3, 32'h0012_3456, 4'b0001);

        for (int k = 0; k < 16; k++) begin
            run_write("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      $urandom, 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
